// File: rtl/conv_loop_sequencer_pkg.sv
// Shared types and default geometry for the convolution loop sequencer.
// Holds the FSM state encoding and the output-pixel address helper.
package conv_loop_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int DEF_K           = 5;
  localparam int DEF_OUT_SIZE    = 28;
  localparam int DEF_OUT_CHANNEL = 6;
  localparam int DEF_IN_CHANNEL  = 1;
  localparam int DEF_OUT_LAT     = 9;

  localparam int ITER_W = 8;
  localparam int TAP_W  = 4;
  localparam int ADDR_W = 16;

  // m*side^2 + r*side + c, evaluated in 16-bit arithmetic
  function automatic logic [ADDR_W-1:0] pixel_addr(
    input logic [ITER_W-1:0] m_v,
    input logic [ITER_W-1:0] r_v,
    input logic [ITER_W-1:0] c_v,
    input logic [ADDR_W-1:0] side
  );
    logic [ADDR_W-1:0] acc;
    acc = {8'd0, m_v} * side + {8'd0, r_v};
    acc = acc * side + {8'd0, c_v};
    return acc;
  endfunction

endpackage

// File: rtl/conv_delay_line.sv
// Fixed-depth shift register that carries the output write strobe and address.
// Shifts only when shift_i is high, so a stalled pipeline keeps every stage intact.
module conv_delay_line #(
  parameter int W     = 17,
  parameter int DEPTH = 9
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         shift_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < DEPTH; s++) pipe_q[s] <= '0;
    end else if (shift_i) begin
      pipe_q[0] <= d_i;
      for (int s = 1; s < DEPTH; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv_loop_sequencer.sv
// Walks m,r,c,n,i,j for one convolution layer and emits accumulator strobes,
// plus a delayed output-buffer write that lands OUT_LAT cycles after each last tap.
module conv_loop_sequencer
  import conv_loop_sequencer_pkg::*;
#(
  parameter int K           = DEF_K,
  parameter int OUT_SIZE    = DEF_OUT_SIZE,
  parameter int OUT_CHANNEL = DEF_OUT_CHANNEL,
  parameter int IN_CHANNEL  = DEF_IN_CHANNEL,
  parameter int OUT_LAT     = DEF_OUT_LAT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stall,
  output logic [7:0]  m,
  output logic [7:0]  r,
  output logic [7:0]  c,
  output logic [7:0]  n,
  output logic [3:0]  i,
  output logic [3:0]  j,
  output logic        iter_valid,
  output logic        acc_clear,
  output logic        acc_last,
  output logic        out_wr,
  output logic [15:0] out_addr,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0]  K_MAX    = 4'(K - 1);
  localparam logic [7:0]  SIDE_MAX = 8'(OUT_SIZE - 1);
  localparam logic [7:0]  CH_MAX   = 8'(OUT_CHANNEL - 1);
  localparam logic [7:0]  N_MAX    = 8'(4 * (IN_CHANNEL - 1));
  localparam logic [7:0]  LAT_MAX  = 8'(OUT_LAT - 1);
  localparam logic [15:0] SIDE     = 16'(OUT_SIZE);

  seq_state_e  state_q, state_d;
  logic [7:0]  m_q, r_q, c_q, n_q, m_d, r_d, c_d, n_d;
  logic [3:0]  i_q, j_q, i_d, j_d;
  logic [7:0]  drain_q, drain_d;
  logic        j_end, i_end, n_end, c_end, r_end, m_end;
  logic [15:0] issue_addr;

  // Carry chain: each *_end means this iterator and every inner one are at max
  assign j_end = (j_q == K_MAX);
  assign i_end = j_end && (i_q == K_MAX);
  assign n_end = i_end && (n_q == N_MAX);
  assign c_end = n_end && (c_q == SIDE_MAX);
  assign r_end = c_end && (r_q == SIDE_MAX);
  assign m_end = r_end && (m_q == CH_MAX);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    r_d     = r_q;
    c_d     = c_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          // On the final tap every iterator wraps, leaving them all at zero
          j_d = j_end ? 4'd0 : j_q + 4'd1;
          if (j_end) i_d = i_end ? 4'd0 : i_q + 4'd1;
          if (i_end) n_d = n_end ? 8'd0 : n_q + 8'd4;
          if (n_end) c_d = c_end ? 8'd0 : c_q + 8'd1;
          if (c_end) r_d = r_end ? 8'd0 : r_q + 8'd1;
          if (r_end) m_d = m_end ? 8'd0 : m_q + 8'd1;
          if (m_end) begin
            state_d = ST_DRAIN;
            drain_d = 8'd0;
          end
        end
      end
      ST_DRAIN: begin
        if (!stall) begin
          if (drain_q == LAT_MAX) begin
            state_d = ST_DONE;
            drain_d = 8'd0;
          end else begin
            drain_d = drain_q + 8'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      r_q     <= r_d;
      c_q     <= c_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      drain_q <= drain_d;
    end
  end

  assign m          = m_q;
  assign r          = r_q;
  assign c          = c_q;
  assign n          = n_q;
  assign i          = i_q;
  assign j          = j_q;
  assign iter_valid = (state_q == ST_RUN);
  assign acc_clear  = iter_valid && (n_q == 8'd0) && (i_q == 4'd0) && (j_q == 4'd0);
  assign acc_last   = iter_valid && n_end;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);

  // Address is zeroed on non-final taps so out_addr only moves with out_wr
  assign issue_addr = acc_last ? pixel_addr(m_q, r_q, c_q, SIDE) : 16'd0;

  conv_delay_line #(
    .W     (17),
    .DEPTH (OUT_LAT)
  ) u_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .shift_i (!stall),
    .d_i     ({acc_last, issue_addr}),
    .q_o     ({out_wr, out_addr})
  );

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Self-checking bench: a tap-list model built from nested loops predicts every output each cycle.
// Small geometry (K=3, 3x3 output, 2 out channels, 2 in-channel groups, latency 4) keeps runs short.
module tb_conv_loop_sequencer;

  localparam int K    = 3;
  localparam int OS   = 3;
  localparam int OC   = 2;
  localparam int IC   = 2;
  localparam int LAT  = 4;
  localparam int TAPS = OC * OS * OS * IC * K * K;
  localparam int PIX  = OC * OS * OS;

  logic        clock, reset_n, start, stall;
  logic [7:0]  d_m, d_r, d_c, d_n;
  logic [3:0]  d_i, d_j;
  logic        iter_valid, acc_clear, acc_last, out_wr, busy, done;
  logic [15:0] out_addr;

  conv_loop_sequencer #(
    .K(K), .OUT_SIZE(OS), .OUT_CHANNEL(OC), .IN_CHANNEL(IC), .OUT_LAT(LAT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stall(stall),
    .m(d_m), .r(d_r), .c(d_c), .n(d_n), .i(d_i), .j(d_j),
    .iter_valid(iter_valid), .acc_clear(acc_clear), .acc_last(acc_last),
    .out_wr(out_wr), .out_addr(out_addr), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    int m, r, c, n, i, j;
    bit first, last;
    int addr;
  } tap_t;
  tap_t taps[$];

  typedef struct {
    int addr;
    int left;
  } pend_t;
  pend_t pend[$];

  task automatic build_taps();
    tap_t t;
    taps.delete();
    for (int mm = 0; mm < OC; mm++)
      for (int rr = 0; rr < OS; rr++)
        for (int cc = 0; cc < OS; cc++)
          for (int nn = 0; nn < IC; nn++)
            for (int ii = 0; ii < K; ii++)
              for (int jj = 0; jj < K; jj++) begin
                t.m = mm; t.r = rr; t.c = cc; t.n = 4 * nn; t.i = ii; t.j = jj;
                t.first = (nn == 0 && ii == 0 && jj == 0);
                t.last  = (nn == IC - 1 && ii == K - 1 && jj == K - 1);
                t.addr  = mm * OS * OS + rr * OS + cc;
                taps.push_back(t);
              end
  endtask

  // Model: phase 0 idle, 1 issuing taps[k], 2 draining, 3 done pulse
  int ph = 0;
  int k = 0;
  int drain_left = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ph = 0; k = 0; drain_left = 0;
      pend.delete();
    end else begin
      if (!stall) begin
        if (pend.size() > 0 && pend[0].left == 0) void'(pend.pop_front());
        foreach (pend[q]) pend[q].left--;
        if (ph == 1 && taps[k].last) pend.push_back('{taps[k].addr, LAT - 1});
      end
      case (ph)
        0: if (start) begin ph = 1; k = 0; end
        1: if (!stall) begin
             k++;
             if (k == TAPS) begin ph = 2; k = 0; drain_left = LAT; end
           end
        2: if (!stall) begin
             drain_left--;
             if (drain_left == 0) ph = 3;
           end
        default: ph = 0;
      endcase
    end
  end

  bit cmp_en = 0;

  always @(negedge clock) begin
    if (cmp_en) begin
      tap_t t;
      logic [39:0] exp_it;
      logic [2:0]  exp_st;
      logic        exp_wr;
      exp_it = '0;
      exp_st = '0;
      if (ph == 1) begin
        t = taps[k];
        exp_it = {8'(t.m), 8'(t.r), 8'(t.c), 8'(t.n), 4'(t.i), 4'(t.j)};
        exp_st = {1'b1, t.first, t.last};
      end
      exp_wr = (pend.size() > 0) && (pend[0].left == 0);
      chk("iterators", 64'({d_m, d_r, d_c, d_n, d_i, d_j}), 64'(exp_it));
      chk("strobes", 64'({iter_valid, acc_clear, acc_last}), 64'(exp_st));
      chk("busy_done", 64'({busy, done}), 64'({ph == 1 || ph == 2, ph == 3}));
      chk("out_wr", 64'(out_wr), 64'(exp_wr));
      if (exp_wr) chk("out_addr", 64'(out_addr), 64'(pend[0].addr));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode 0: clean; 1: 3-cycle stall on tap 5 plus a mid-run start; 2: random stall/start
  task automatic run_layer(input int mode, output int cyc, output int nv, output int nw,
                           output int last_addr, output int nstall);
    start = 1'b1;
    cyc = 0; nv = 0; nw = 0; last_addr = -1; nstall = 0;
    do begin
      tick();
      cyc++;
      start = 1'b0;
      stall = 1'b0;
      if (mode == 1) begin
        stall = (cyc >= 6 && cyc <= 8);
        start = (cyc == 50);
      end else if (mode == 2) begin
        stall = ($urandom_range(0, 3) == 0);
        start = ($urandom_range(0, 9) == 0);
      end
      if (stall && busy) nstall++;
      if (iter_valid && !stall) nv++;
      if (out_wr && !stall) begin
        nw++;
        last_addr = int'(out_addr);
      end
    end while (!done && cyc < 4000);
    if (!done) $display("FAIL layer_timeout: got no done after %0d cycles, expected done", cyc);
    chk("layer_done_seen", 64'(done), 64'(1));
    stall = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nv, nw, la, ns, nlast, guard;
    reset_n = 1'b0; start = 1'b0; stall = 1'b0;
    build_taps();

    // Hand-computed pins on the model itself
    nlast = 0;
    foreach (taps[q]) if (taps[q].last) nlast++;
    chk("model_tap_count", 64'(taps.size()), 64'(324));
    chk("model_pixel_count", 64'(nlast), 64'(18));
    chk("model_tap5", 64'({8'(taps[5].m), 8'(taps[5].r), 8'(taps[5].c), 8'(taps[5].n),
                           4'(taps[5].i), 4'(taps[5].j)}), 64'(40'h00_00_00_00_1_2));
    chk("model_tap9_n", 64'(taps[9].n), 64'(4));
    chk("model_tap18_first", 64'({taps[18].c, 31'(taps[18].first)}), 64'({32'd1, 31'd1}));
    chk("model_last_addr", 64'(taps[TAPS-1].addr), 64'(17));

    repeat (3) tick();
    chk("reset_outputs", 64'({d_m, d_r, d_c, d_n, d_i, d_j, iter_valid, acc_clear, acc_last,
                              out_wr, out_addr, busy, done}), 64'(0));
    cmp_en = 1;

    // Start is presented on the same cycle reset releases
    reset_n = 1'b1;
    run_layer(0, cyc, nv, nw, la, ns);
    chk("clean_done_cycle", 64'(cyc), 64'(TAPS + LAT + 1));
    chk("clean_issue_count", 64'(nv), 64'(TAPS));
    chk("clean_wr_count", 64'(nw), 64'(PIX));
    chk("clean_last_addr", 64'(la), 64'(17));

    tick();
    run_layer(1, cyc, nv, nw, la, ns);
    chk("stall_done_cycle", 64'(cyc), 64'(332));
    chk("stall_issue_count", 64'(nv), 64'(TAPS));
    chk("stall_wr_count", 64'(nw), 64'(PIX));
    // Start coinciding with done must not launch a new layer
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_on_done_busy", 64'(busy), 64'(0));
    tick();
    chk("start_on_done_valid", 64'(iter_valid), 64'(0));

    for (int rep = 0; rep < 2; rep++) begin
      tick();
      run_layer(2, cyc, nv, nw, la, ns);
      chk("rand_done_cycle", 64'(cyc), 64'(TAPS + LAT + 1 + ns));
      chk("rand_issue_count", 64'(nv), 64'(TAPS));
      chk("rand_wr_count", 64'(nw), 64'(PIX));
      chk("rand_last_addr", 64'(la), 64'(17));
    end

    // Mid-layer reset while r==2
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(iter_valid && d_r == 8'd2) && guard < 1000) begin
      tick();
      guard++;
    end
    chk("reached_r2", 64'(d_r), 64'(2));
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({d_m, d_r, d_c, d_n, d_i, d_j, iter_valid, acc_clear,
                                    acc_last, out_wr, out_addr, busy, done}), 64'(0));
    tick();
    tick();
    reset_n = 1'b1;
    run_layer(0, cyc, nv, nw, la, ns);
    chk("post_reset_done_cycle", 64'(cyc), 64'(TAPS + LAT + 1));
    chk("post_reset_issue_count", 64'(nv), 64'(TAPS));
    chk("post_reset_wr_count", 64'(nw), 64'(PIX));

    tick();
    tick();
    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
